sensor_stream_arbiter: RTL and testbench

Collects 110-bit packets from up to N_SENSORS ion sensor channels. Each channel delivers a packet as a one-cycle ready pulse plus data. The block buffers one packet per channel, picks the next channel round-robin, and sends the packet as a byte stream (channel header, then payload MSB-first) to the Bluetooth/UART transmitter using a valid/ack handshake.

---
 rtl/sensor_stream_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sensor_stream_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_stream_arbiter.sv
// Buffers one packet per sensor channel, picks channels round-robin and streams
// each packet as a header byte plus MSB-first payload bytes over valid/ack.
module sensor_stream_arbiter #(
  parameter int unsigned N_SENSORS = 8,
  parameter int unsigned DATA_W    = 110
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [N_SENSORS-1:0]          sensor_ready,
  input  logic [N_SENSORS*DATA_W-1:0]   sensor_data,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ack,
  output logic                          busy,
  output logic [N_SENSORS-1:0]          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned NBYTES = (DATA_W + 7) / 8;
  localparam int unsigned SH_W   = NBYTES * 8;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned CNT_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [N_SENSORS-1:0]   pending, pending_n;
  logic [N_SENSORS-1:0]   overflow_n;
  logic [N_SENSORS-1:0]   grant, capture;
  logic [DATA_W-1:0]      hold [N_SENSORS];
  logic [SH_W-1:0]        shift, shift_n, shifted;
  logic [CNT_W-1:0]       byte_cnt, cnt_n;
  logic [CH_W-1:0]        last_grant, last_n;
  logic [CH_W-1:0]        ch, ch_n;
  logic [CH_W-1:0]        grant_idx;
  logic                   grant_found;
  logic                   valid_n;
  logic [7:0]             data_n;

  // Round-robin search: first pending channel after the last granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= int'(N_SENSORS); off++) begin
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (!grant_found && pending[i] &&
            i == (int'(last_grant) + off) % int'(N_SENSORS)) begin
          grant_found = 1'b1;
          grant_idx   = CH_W'(i);
        end
      end
    end
  end

  // Next-state, capture/overflow bookkeeping and the next registered outputs.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    cnt_n      = byte_cnt;
    last_n     = last_grant;
    ch_n       = ch;
    grant      = '0;
    capture    = '0;
    pending_n  = pending;
    overflow_n = overflow;
    valid_n    = 1'b0;
    data_n     = 8'h00;
    shifted    = '0;

    case (state)
      IDLE: begin
        if (enable && grant_found) begin
          for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (CH_W'(i) == grant_idx) begin
              grant[i] = 1'b1;
              shift_n  = SH_W'(hold[i]);
            end
          end
          last_n  = grant_idx;
          ch_n    = grant_idx;
          state_n = HDR;
        end
      end
      HDR: begin
        if (tx_ack) begin
          cnt_n   = '0;
          state_n = BODY;
        end
      end
      BODY: begin
        if (tx_ack) begin
          if (byte_cnt == CNT_W'(NBYTES - 1)) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = byte_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (clear_overflow) overflow_n = '0;
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      if (grant[i]) pending_n[i] = 1'b0;
      if (sensor_ready[i]) begin
        if (!pending[i] || grant[i]) begin
          capture[i]   = 1'b1;
          pending_n[i] = 1'b1;
        end else begin
          overflow_n[i] = 1'b1;
        end
      end
    end

    // Outputs are registered, so they are derived from the next state.
    shifted = shift_n >> (8 * (NBYTES - 1 - int'(cnt_n)));
    case (state_n)
      HDR: begin
        valid_n = 1'b1;
        data_n  = {4'hA, ch_n};
      end
      BODY: begin
        valid_n = 1'b1;
        data_n  = shifted[7:0];
      end
      default: begin
        valid_n = 1'b0;
        data_n  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pending    <= '0;
      overflow   <= '0;
      shift      <= '0;
      byte_cnt   <= '0;
      last_grant <= CH_W'(N_SENSORS - 1);
      ch         <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      for (int i = 0; i < int'(N_SENSORS); i++) hold[i] <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      overflow   <= overflow_n;
      shift      <= shift_n;
      byte_cnt   <= cnt_n;
      last_grant <= last_n;
      ch         <= ch_n;
      tx_valid   <= valid_n;
      tx_data    <= data_n;
      busy       <= (state_n != IDLE);
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (capture[i]) hold[i] <= sensor_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_sensor_stream_arbiter.sv
// Bench for sensor_stream_arbiter: queue-based packet model checked every cycle,
// plus directed scenarios with literal byte expectations.
module tb_sensor_stream_arbiter;

  localparam int N  = 8;
  localparam int DW = 110;
  localparam int NB = 14;

  logic              clock = 1'b0;
  logic              resetn = 1'b1;
  logic              enable = 1'b0;
  logic [N-1:0]      sensor_ready = '0;
  logic [N*DW-1:0]   sensor_data = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ack = 1'b0;
  logic              busy;
  logic [N-1:0]      overflow;
  logic              clear_overflow = 1'b0;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  sensor_stream_arbiter #(.N_SENSORS(N), .DATA_W(DW)) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .sensor_ready(sensor_ready), .sensor_data(sensor_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .busy(busy), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-channel buffers plus the queue of bytes still owed to the link.
  logic [DW-1:0] m_hold [N];
  logic [N-1:0]  m_pend = '0;
  logic [N-1:0]  m_ovf  = '0;
  int            m_last = N - 1;
  logic [7:0]    mq [$];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) m_hold[i] = '0;
      m_pend = '0;
      m_ovf  = '0;
      m_last = N - 1;
      mq.delete();
    end else begin
      bit idle;
      int g;
      logic [NB*8-1:0] w;
      idle = (mq.size() == 0);
      if (!idle && tx_ack) void'(mq.pop_front());
      g = -1;
      if (idle && enable) begin
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (m_last + off) % N;
          if (g < 0 && m_pend[c]) g = c;
        end
      end
      if (g >= 0) begin
        mq.push_back(8'hA0 | 8'(g));
        w = '0;
        w[DW-1:0] = m_hold[g];
        for (int b = NB - 1; b >= 0; b--) mq.push_back(w[b*8 +: 8]);
        m_pend[g] = 1'b0;
        m_last = g;
      end
      if (clear_overflow) m_ovf = '0;
      for (int i = 0; i < N; i++) begin
        if (sensor_ready[i]) begin
          if (!m_pend[i]) begin
            m_hold[i] = sensor_data[i*DW +: DW];
            m_pend[i] = 1'b1;
          end else begin
            m_ovf[i] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    wait (started);
    forever begin
      @(negedge clock);
      #1;
      chk("cyc_valid", tx_valid, mq.size() > 0);
      chk("cyc_data", tx_data, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("cyc_busy", busy, mq.size() > 0);
      chk("cyc_ovf", overflow, m_ovf);
    end
  end

  // Bytes actually accepted by the transmitter.
  logic [7:0] log_q [$];
  always @(posedge clock) if (resetn && tx_valid && tx_ack) log_q.push_back(tx_data);

  task automatic set_data(input int c, input logic [DW-1:0] d);
    sensor_data[c*DW +: DW] = d;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clock);
    sensor_ready = m;
    @(negedge clock);
    sensor_ready = '0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk("wait_log_timeout", 128'(log_q.size() >= n), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    sensor_ready = '0;
    enable = 1'b0;
    tx_ack = 1'b0;
    clear_overflow = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    log_q.delete();
  endtask

  logic [DW-1:0] d1, da, db, d2;
  logic [7:0] exp1 [15];

  initial begin
    d1 = {6'h3F, 104'h0102030405060708090A0B0C0D};
    da = {6'h2A, 104'h11223344556677889900AABBCC};
    db = {6'h01, 104'hF0E0D0C0B0A090807060504055};
    d2 = {6'h12, 104'h00000000000000000000000077};
    exp1 = '{8'hA0, 8'h3F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D};

    #2 resetn = 1'b0;
    started = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    #2;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", tx_data, 0);

    // 1: single packet, full-rate ack
    do_reset();
    enable = 1'b1;
    tx_ack = 1'b1;
    set_data(0, d1);
    pulse(8'b0000_0001);
    #2 chk("t1_lat_before", tx_valid, 0);
    @(negedge clock);
    #2 chk("t1_lat_valid", tx_valid, 1);
    chk("t1_lat_hdr", tx_data, 8'hA0);
    wait_log(15, 100);
    repeat (3) @(negedge clock);
    chk("t1_count", log_q.size(), 15);
    for (int i = 0; i < 15; i++) chk($sformatf("t1_byte%0d", i), log_q[i], exp1[i]);
    chk("t1_busy_end", busy, 0);

    // 2: backpressure with ack pattern 1,0,0
    do_reset();
    enable = 1'b1;
    set_data(0, d1);
    pulse(8'b0000_0001);
    for (int c = 0; c < 200 && log_q.size() < 15; c++) begin
      @(negedge clock);
      tx_ack = (c % 3 == 0);
    end
    tx_ack = 1'b1;
    repeat (5) @(negedge clock);
    chk("t2_count", log_q.size(), 15);
    for (int i = 0; i < 15; i++) chk($sformatf("t2_byte%0d", i), log_q[i], exp1[i]);

    // 3: round-robin order
    do_reset();
    enable = 1'b1;
    tx_ack = 1'b1;
    set_data(5, d1);
    set_data(2, da);
    set_data(7, db);
    pulse(8'b1010_0100);
    wait_log(31, 200);
    set_data(2, d2);
    set_data(5, da);
    pulse(8'b0010_0100);
    wait_log(75, 300);
    chk("t3_hdr0", log_q[0], 8'hA2);
    chk("t3_hdr1", log_q[15], 8'hA5);
    chk("t3_hdr2", log_q[30], 8'hA7);
    chk("t3_hdr3", log_q[45], 8'hA2);
    chk("t3_hdr4", log_q[60], 8'hA5);
    chk("t3_b3_last", log_q[59], 8'h77);

    // 4: overflow while disabled, clear, then send retained data
    do_reset();
    tx_ack = 1'b1;
    set_data(3, da);
    pulse(8'b0000_1000);
    set_data(3, db);
    pulse(8'b0000_1000);
    #2 chk("t4_ovf_set", overflow, 8'b0000_1000);
    @(negedge clock);
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    #2 chk("t4_ovf_clr", overflow, 8'h00);
    @(negedge clock);
    enable = 1'b1;
    wait_log(15, 100);
    chk("t4_hdr", log_q[0], 8'hA3);
    chk("t4_first", log_q[1], 8'h2A);
    chk("t4_last", log_q[14], 8'hCC);

    // 5: new pulse on the grant edge of the same channel
    do_reset();
    tx_ack = 1'b1;
    set_data(1, da);
    pulse(8'b0000_0010);
    @(negedge clock);
    enable = 1'b1;
    set_data(1, db);
    sensor_ready = 8'b0000_0010;
    @(negedge clock);
    sensor_ready = '0;
    wait_log(30, 150);
    chk("t5_hdr_a", log_q[0], 8'hA1);
    chk("t5_old", log_q[1], 8'h2A);
    chk("t5_hdr_b", log_q[15], 8'hA1);
    chk("t5_new", log_q[16], 8'h01);
    chk("t5_new_last", log_q[29], 8'h55);
    chk("t5_ovf", overflow, 8'h00);

    // 6: reset during body byte 5
    do_reset();
    enable = 1'b1;
    tx_ack = 1'b1;
    set_data(0, d1);
    pulse(8'b0000_0001);
    wait_log(2, 50);
    pulse(8'b0001_0000);
    pulse(8'b0001_0000);
    wait_log(6, 50);
    #2 chk("t6_ovf_pre", overflow, 8'h10);
    chk("t6_body5", tx_data, 8'h05);
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", tx_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", overflow, 8'h00);
    @(negedge clock);
    resetn = 1'b1;
    log_q.delete();
    enable = 1'b1;
    tx_ack = 1'b1;
    set_data(0, d2);
    pulse(8'b0000_0001);
    wait_log(15, 100);
    repeat (20) @(negedge clock);
    chk("t6_count", log_q.size(), 15);
    chk("t6_hdr", log_q[0], 8'hA0);
    chk("t6_first", log_q[1], 8'h12);
    chk("t6_last", log_q[14], 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
